jrb_regfile: RTL and testbench

- Parametrised register/IO block for the next-generation jrb computer.
- Replaces the fixed A/B/C/D/MAR/MPAGE/O/I register set and its one-hot priority write chain with:
  - an addressed write port;
  - two ALU operand read ports;
  - a memory-address register pair;
  - a handshaked output port;
  - a sampled input port.
- Sits between the CU/databus (writes), the ALU (operand reads) and the SPI memory controller (address).

---
 rtl/jrb_pkg.sv | 27 ++
 rtl/jrb_out_port.sv | 41 ++++
 rtl/jrb_regfile.sv | 119 +++++++++++
 tb/tb_jrb_regfile.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/jrb_pkg.sv
// jrb_pkg: shared definitions for the jrb register/IO block.
//   - MAR_IDX / MPAGE_IDX / OUT_IDX: write addresses of the special registers,
//     which sit directly above the NREGS general-purpose registers.
//   - wr_kind_e: result of decoding a write address.
package jrb_pkg;

  typedef enum logic [2:0] {
    WR_GPR,
    WR_MAR,
    WR_MPAGE,
    WR_OUT,
    WR_BAD
  } wr_kind_e;

  function automatic int MAR_IDX(input int nregs);
    return nregs;
  endfunction

  function automatic int MPAGE_IDX(input int nregs);
    return nregs + 1;
  endfunction

  function automatic int OUT_IDX(input int nregs);
    return nregs + 2;
  endfunction

endpackage

// File: rtl/jrb_out_port.sv
// jrb_out_port: OUT register with valid/ack handshake.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   wr_sel       write request targeting OUT (wr_en && decode == OUT)
//   wr_data      value to load
//   rdy          OUT can take a write this cycle
//   out_data     OUT register (holds after ack)
//   out_valid    OUT holds unconsumed data
//   out_ack      consumer takes OUT
module jrb_out_port #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ack
);

  logic load;

  // A same-cycle ack frees the slot, so a new value can land on that edge.
  assign rdy  = !(out_valid && !out_ack);
  assign load = wr_sel && rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= wr_data;
      out_valid <= 1'b1;
    end else if (out_ack && out_valid) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/jrb_regfile.sv
// jrb_regfile: parametrised register/IO block.
//   Addressed write port (GPRs, MAR, MPAGE, OUT), two GPR read ports for the
//   ALU, {MPAGE,MAR} memory address, handshaked OUT port, sampled input.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   wr_en/wr_addr/wr_data       write request; wr_ready accepts, wr_err flags
//                               a write to an unmapped address (1-cycle pulse)
//   rda_*/rdb_*                 combinational GPR reads (0 when disabled/out of range)
//   mem_addr                    {MPAGE, MAR}
//   out_data/out_valid/out_ack  OUT handshake
//   in_pins/in_data             sampled input
// Build option: JRB_REGFILE_INSYNC_EN adds a two-flop synchroniser ahead of
// the input sample register (in_data latency 3 instead of 1).
module jrb_regfile
  import jrb_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int NREGS = 4,
  localparam int AW    = $clog2(NREGS + 3)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [WIDTH-1:0]   wr_data,
  output logic               wr_ready,
  output logic               wr_err,
  input  logic               rda_en,
  input  logic [AW-1:0]      rda_addr,
  output logic [WIDTH-1:0]   rda_data,
  input  logic               rdb_en,
  input  logic [AW-1:0]      rdb_addr,
  output logic [WIDTH-1:0]   rdb_data,
  output logic [2*WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ack,
  input  logic [WIDTH-1:0]   in_pins,
  output logic [WIDTH-1:0]   in_data
);

  logic [NREGS-1:0][WIDTH-1:0] gpr;
  logic [WIDTH-1:0]            mar, mpage;
  wr_kind_e                    wr_kind;
  logic                        wr_acc;
  logic                        out_rdy;

  always_comb begin
    wr_kind = WR_BAD;
    if (wr_addr < AW'(NREGS))                       wr_kind = WR_GPR;
    else if (wr_addr == AW'(MAR_IDX(NREGS)))   wr_kind = WR_MAR;
    else if (wr_addr == AW'(MPAGE_IDX(NREGS))) wr_kind = WR_MPAGE;
    else if (wr_addr == AW'(OUT_IDX(NREGS)))   wr_kind = WR_OUT;
  end

  // Only OUT can stall; every other target (including bad ones) is ready.
  assign wr_ready = (wr_kind != WR_OUT) || out_rdy;
  assign wr_acc   = wr_en && wr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gpr    <= '0;
      mar    <= '0;
      mpage  <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && (wr_kind == WR_BAD);
      if (wr_acc) begin
        for (int i = 0; i < NREGS; i++)
          if (wr_kind == WR_GPR && wr_addr == AW'(i)) gpr[i] <= wr_data;
        if (wr_kind == WR_MAR)   mar   <= wr_data;
        if (wr_kind == WR_MPAGE) mpage <= wr_data;
      end
    end
  end

  // Reads see registered state only; a write shows up the following cycle.
  always_comb begin
    rda_data = '0;
    rdb_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (rda_en && rda_addr == AW'(i)) rda_data = gpr[i];
      if (rdb_en && rdb_addr == AW'(i)) rdb_data = gpr[i];
    end
  end

  assign mem_addr = {mpage, mar};

  jrb_out_port #(.WIDTH(WIDTH)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_sel    (wr_en && (wr_kind == WR_OUT)),
    .wr_data   (wr_data),
    .rdy       (out_rdy),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ack   (out_ack)
  );

`ifdef JRB_REGFILE_INSYNC_EN
  logic [1:0][WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      in_data <= '0;
    end else begin
      sync_q  <= {sync_q[0], in_pins};
      in_data <= sync_q[1];
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_data <= '0;
    else        in_data <= in_pins;
  end
`endif

endmodule

// File: tb/tb_jrb_regfile.sv
// Directed bench for jrb_regfile (WIDTH=8, NREGS=4). Inputs are driven 1ns
// after the rising edge, outputs checked 1ns later.
module tb_jrb_regfile;

  localparam int WIDTH = 8;
  localparam int NREGS = 4;
  localparam int AW    = 3;
`ifdef JRB_REGFILE_INSYNC_EN
  localparam int IN_LAT = 3;
`else
  localparam int IN_LAT = 1;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic               wr_ready, wr_err;
  logic               rda_en, rdb_en;
  logic [AW-1:0]      rda_addr, rdb_addr;
  logic [WIDTH-1:0]   rda_data, rdb_data;
  logic [2*WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid, out_ack;
  logic [WIDTH-1:0]   in_pins, in_data;

  int n_vec = 0;
  int n_err = 0;

  jrb_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_err(wr_err),
    .rda_en(rda_en), .rda_addr(rda_addr), .rda_data(rda_data),
    .rdb_en(rdb_en), .rdb_addr(rdb_addr), .rdb_data(rdb_data),
    .mem_addr(mem_addr),
    .out_data(out_data), .out_valid(out_valid), .out_ack(out_ack),
    .in_pins(in_pins), .in_data(in_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    wr_en = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rda_en = 1'b0; rda_addr = '0; rdb_en = 1'b0; rdb_addr = '0;
    out_ack = 1'b0; in_pins = '0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Post-reset state
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data",  out_data,  0);
    chk("rst_mem_addr",  mem_addr,  0);
    chk("rst_in_data",   in_data,   0);
    chk("rst_wr_err",    wr_err,    0);
    chk("rst_wr_ready",  wr_ready,  1);

    // Load state, then reset mid-OUT-transfer without a clock edge
    rda_en = 1'b1; rda_addr = 3'd0;
    wr(3'd0, 8'h11);
    wr(3'd4, 8'h77);
    wr(3'd6, 8'h99);
    in_pins = 8'hFF;
    repeat (IN_LAT) tick();
    chk("pre_rst_out_valid", out_valid, 1);
    chk("pre_rst_gpr0",      rda_data,  8'h11);
    chk("pre_rst_in_data",   in_data,   8'hFF);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data",  out_data,  0);
    chk("arst_mem_addr",  mem_addr,  0);
    chk("arst_gpr0",      rda_data,  0);
    chk("arst_in_data",   in_data,   0);
    in_pins = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // GPR write/read, no bypass
    rda_en = 1'b1; rda_addr = 3'd2; rdb_en = 1'b1; rdb_addr = 3'd2;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h5A;
    #1;
    chk("gpr_pre_edge_rda", rda_data, 8'h00);
    tick();
    wr_en = 1'b0;
    #1;
    chk("gpr_rda", rda_data, 8'h5A);
    chk("gpr_rdb", rdb_data, 8'h5A);
    rdb_en = 1'b0;
    #1;
    chk("gpr_rdb_disabled", rdb_data, 8'h00);
    rdb_en = 1'b1; rdb_addr = 3'd5;
    #1;
    chk("gpr_rdb_out_of_range", rdb_data, 8'h00);
    rdb_addr = 3'd2;

    // Memory address pair
    wr(3'd4, 8'h34);
    chk("mem_mar", mem_addr, 16'h0034);
    wr(3'd5, 8'h12);
    chk("mem_page", mem_addr, 16'h1234);

    // OUT handshake with backpressure
    wr(3'd6, 8'hAA);
    chk("out_valid_set", out_valid, 1);
    chk("out_data_aa",   out_data,  8'hAA);
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 8'hBB; out_ack = 1'b0;
    #1;
    chk("out_stall_ready", wr_ready, 0);
    chk("gpr_write_ready", 32'(wr_ready | (wr_addr != 3'd6)), 0);
    tick();
    chk("out_stall_data", out_data, 8'hAA);
    out_ack = 1'b1;
    #1;
    chk("out_ack_ready", wr_ready, 1);
    tick();
    wr_en = 1'b0; out_ack = 1'b0;
    #1;
    chk("out_data_bb",     out_data,  8'hBB);
    chk("out_valid_held",  out_valid, 1);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    #1;
    chk("out_valid_clr",   out_valid, 0);
    chk("out_data_kept",   out_data,  8'hBB);
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
    chk("out_idle_ack",    out_valid, 0);

    // Invalid address
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 8'hEE;
    #1;
    chk("bad_ready", wr_ready, 1);
    chk("bad_err_pre", wr_err, 0);
    tick();
    wr_en = 1'b0;
    #1;
    chk("bad_err_pulse", wr_err,    1);
    chk("bad_mem_addr",  mem_addr,  16'h1234);
    chk("bad_out_data",  out_data,  8'hBB);
    chk("bad_out_valid", out_valid, 0);
    chk("bad_gpr2",      rda_data,  8'h5A);
    tick();
    chk("bad_err_clear", wr_err, 0);

    // Input sampling latency
    in_pins = 8'hC3;
    for (int k = 1; k <= IN_LAT; k++) begin
      tick();
      chk($sformatf("in_lat_%0d", k), in_data, (k == IN_LAT) ? 8'hC3 : 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
